change_dispenser: RTL and testbench

Returns change after a vend. Takes the inserted credit and the product price, then drives a coin hopper one coin at a time using a req/ack handshake. Uses a greedy largest-denomination-first algorithm. It sits downstream of the money counter and the purchase FSM's DISPENSE state, and uses the same 2-bit coin encoding as the money counter.

---
 rtl/change_dispenser.sv | 144 ++++++++++++++
 tb/tb_change_dispenser.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy change dispenser driving a coin hopper over a req/ack handshake
// Optional hopper counters: CHANGE_DISPENSER_HOPPER_COUNT_EN
module change_dispenser #(
    parameter int CREDIT_W    = 16,
    parameter int HOPPER_INIT = 20,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [CREDIT_W-1:0] credit,
    input  logic [CREDIT_W-1:0] price,
    input  logic                coin_ack,
    input  logic                refill,
    output logic                coin_req,
    output logic [1:0]          coin_sel,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [CREDIT_W-1:0] change_left
);

    typedef enum logic [2:0] {IDLE, CALC, SELECT, ISSUE, DONE, FAULT} state_t;

    state_t              state;
    logic [CREDIT_W-1:0] credit_q;
    logic [CREDIT_W-1:0] price_q;
    logic [3:0]          avail;
    logic                found;
    logic [1:0]          pick_sel;

    function automatic logic [CREDIT_W-1:0] denom(input logic [1:0] s);
        case (s)
            2'd0:    denom = CREDIT_W'(500);
            2'd1:    denom = CREDIT_W'(1000);
            2'd2:    denom = CREDIT_W'(2000);
            default: denom = CREDIT_W'(5000);
        endcase
    endfunction

`ifdef CHANGE_DISPENSER_HOPPER_COUNT_EN
    logic [CNT_W-1:0] hopper [4];

    always_comb begin
        for (int i = 0; i < 4; i++) avail[i] = (hopper[i] != '0);
    end

    // Decrement happens only on the accepted ack, so a reset mid-coin never loses a count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) hopper[i] <= CNT_W'(HOPPER_INIT);
        end else if (state == IDLE && refill) begin
            for (int i = 0; i < 4; i++) hopper[i] <= CNT_W'(HOPPER_INIT);
        end else if (state == ISSUE && coin_ack) begin
            hopper[coin_sel] <= hopper[coin_sel] - 1'b1;
        end
    end
`else
    wire              unused_refill = refill;
    wire [CNT_W-1:0]  unused_init   = CNT_W'(HOPPER_INIT);

    assign avail = 4'b1111;
`endif

    // Ascending scan: the last qualifying denomination is the largest one.
    always_comb begin
        found    = 1'b0;
        pick_sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (avail[i] && change_left >= denom(i[1:0])) begin
                found    = 1'b1;
                pick_sel = i[1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            credit_q    <= '0;
            price_q     <= '0;
            coin_req    <= 1'b0;
            coin_sel    <= 2'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            change_left <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        credit_q <= credit;
                        price_q  <= price;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (credit_q < price_q) begin
                        error       <= 1'b1;
                        change_left <= '0;
                        state       <= FAULT;
                    end else begin
                        change_left <= credit_q - price_q;
                        state       <= SELECT;
                    end
                end
                SELECT: begin
                    if (change_left == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (found) begin
                        coin_sel <= pick_sel;
                        coin_req <= 1'b1;
                        state    <= ISSUE;
                    end else begin
                        error <= 1'b1;
                        state <= FAULT;
                    end
                end
                ISSUE: begin
                    if (coin_ack) begin
                        change_left <= change_left - denom(coin_sel);
                        coin_req    <= 1'b0;
                        state       <= SELECT;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                FAULT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - scoreboard bench for change_dispenser
module tb_change_dispenser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] credit = '0;
    logic [15:0] price = '0;
    logic        coin_ack = 1'b0;
    logic        refill = 1'b0;
    logic        coin_req;
    logic [1:0]  coin_sel;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] change_left;

    int checks = 0;
    int fails  = 0;

    logic [1:0]  exp_coin [$];
    logic [15:0] exp_left [$];

    change_dispenser #(.CREDIT_W(16), .HOPPER_INIT(1), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .credit(credit), .price(price),
        .coin_ack(coin_ack), .refill(refill), .coin_req(coin_req), .coin_sel(coin_sel),
        .busy(busy), .done(done), .error(error), .change_left(change_left)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic do_start(input logic [15:0] c, input logic [15:0] p);
        credit = c;
        price  = p;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Runs the hopper side until busy drops; compares each coin and remainder against the queues.
    task automatic serve(input int ack_delay, input bit extra_ack, output int coins, output int dones);
        int budget;
        logic [1:0]  sel;
        logic [1:0]  want_sel;
        logic [15:0] want_left;
        logic [15:0] held;
        coins  = 0;
        dones  = 0;
        budget = 0;
        while (busy && budget < 300) begin
            if (done) dones++;
            if (coin_req) begin
                sel = coin_sel;
                checks++;
                if (exp_coin.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_coin: got sel %0d, none expected", sel);
                end else begin
                    want_sel = exp_coin.pop_front();
                    if (sel !== want_sel) begin
                        fails++;
                        $display("FAIL coin_sel: got %0d, expected %0d", sel, want_sel);
                    end
                end
                for (int d = 0; d < ack_delay; d++) begin
                    tick();
                    budget++;
                    checks++;
                    if (coin_req !== 1'b1 || coin_sel !== sel) begin
                        fails++;
                        $display("FAIL hold_stable: req %b sel %0d, expected req 1 sel %0d", coin_req, coin_sel, sel);
                    end
                end
                coin_ack = 1'b1;
                tick();
                coin_ack = 1'b0;
                budget++;
                coins++;
                checks++;
                if (coin_req !== 1'b0) begin
                    fails++;
                    $display("FAIL req_drop: coin_req %b after ack, expected 0", coin_req);
                end
                want_left = exp_left.size() != 0 ? exp_left.pop_front() : 16'hxxxx;
                checks++;
                if (change_left !== want_left) begin
                    fails++;
                    $display("FAIL change_left_after_ack: got %0d, expected %0d", change_left, want_left);
                end
                if (extra_ack) begin
                    held = change_left;
                    coin_ack = 1'b1;
                    tick();
                    coin_ack = 1'b0;
                    budget++;
                    checks++;
                    if (change_left !== held) begin
                        fails++;
                        $display("FAIL stray_ack: change_left %0d, expected %0d", change_left, held);
                    end
                end
            end else begin
                tick();
                budget++;
            end
        end
        checks++;
        if (budget >= 300) begin
            fails++;
            $display("FAIL serve_timeout: busy %b after %0d cycles, expected 0", busy, budget);
        end
        checks++;
        if (exp_coin.size() != 0) begin
            fails++;
            $display("FAIL missing_coins: %0d left, expected 0", exp_coin.size());
        end
        exp_coin.delete();
        exp_left.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if ({coin_req, coin_sel, busy, done, error, change_left} !== 22'd0) begin
            fails++;
            $display("FAIL reset_outputs: req %b sel %0d busy %b done %b err %b left %0d, expected all 0",
                     coin_req, coin_sel, busy, done, error, change_left);
        end
        apply_reset();
    endtask

    task automatic test_change();
        int coins, dones;
        apply_reset();
        exp_coin.push_back(2'd3); exp_left.push_back(16'd1500);
        exp_coin.push_back(2'd1); exp_left.push_back(16'd500);
        exp_coin.push_back(2'd0); exp_left.push_back(16'd0);
        do_start(16'd8500, 16'd2000);
        checks++;
        if (busy !== 1'b1 || coin_req !== 1'b0) begin
            fails++;
            $display("FAIL start_n: busy %b req %b, expected busy 1 req 0", busy, coin_req);
        end
        tick();
        checks++;
        if (change_left !== 16'd6500 || coin_req !== 1'b0) begin
            fails++;
            $display("FAIL calc_n1: left %0d req %b, expected 6500 req 0", change_left, coin_req);
        end
        tick();
        checks++;
        if (coin_req !== 1'b1) begin
            fails++;
            $display("FAIL first_req_n2: req %b, expected 1", coin_req);
        end
        serve(0, 1'b0, coins, dones);
        checks++;
        if (coins != 3 || dones != 1 || error !== 1'b0 || change_left !== 16'd0) begin
            fails++;
            $display("FAIL change_8500: coins %0d done %0d err %b left %0d, expected 3 1 0 0",
                     coins, dones, error, change_left);
        end
    endtask

    task automatic test_underpay();
        apply_reset();
        do_start(16'd1000, 16'd1500);
        checks++;
        if (busy !== 1'b1 || error !== 1'b0) begin
            fails++;
            $display("FAIL underpay_n: busy %b err %b, expected 1 0", busy, error);
        end
        tick();
        checks++;
        if (error !== 1'b1 || coin_req !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL underpay_n1: err %b req %b busy %b, expected 1 0 1", error, coin_req, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || error !== 1'b1 || done !== 1'b0 || coin_req !== 1'b0) begin
            fails++;
            $display("FAIL underpay_n2: busy %b err %b done %b req %b, expected 0 1 0 0",
                     busy, error, done, coin_req);
        end
    endtask

    task automatic test_remainder();
        int coins, dones;
        apply_reset();
        do_start(16'd3000, 16'd2750);
        serve(0, 1'b0, coins, dones);
        checks++;
        if (coins != 0 || dones != 0 || error !== 1'b1 || change_left !== 16'd250) begin
            fails++;
            $display("FAIL remainder_250: coins %0d done %0d err %b left %0d, expected 0 0 1 250",
                     coins, dones, error, change_left);
        end
    endtask

    task automatic test_hopper();
        int coins, dones;
        apply_reset();
`ifdef CHANGE_DISPENSER_HOPPER_COUNT_EN
        exp_coin.push_back(2'd3); exp_left.push_back(16'd10000);
        exp_coin.push_back(2'd2); exp_left.push_back(16'd8000);
        exp_coin.push_back(2'd1); exp_left.push_back(16'd7000);
        exp_coin.push_back(2'd0); exp_left.push_back(16'd6500);
        do_start(16'd15000, 16'd0);
        serve(0, 1'b0, coins, dones);
        checks++;
        if (coins != 4 || dones != 0 || error !== 1'b1 || change_left !== 16'd6500) begin
            fails++;
            $display("FAIL hopper_empty: coins %0d done %0d err %b left %0d, expected 4 0 1 6500",
                     coins, dones, error, change_left);
        end
`else
        exp_coin.push_back(2'd3); exp_left.push_back(16'd10000);
        exp_coin.push_back(2'd3); exp_left.push_back(16'd5000);
        exp_coin.push_back(2'd3); exp_left.push_back(16'd0);
        do_start(16'd15000, 16'd0);
        serve(0, 1'b0, coins, dones);
        checks++;
        if (coins != 3 || dones != 1 || error !== 1'b0 || change_left !== 16'd0) begin
            fails++;
            $display("FAIL hopper_infinite: coins %0d done %0d err %b left %0d, expected 3 1 0 0",
                     coins, dones, error, change_left);
        end
`endif
        refill = 1'b1;
        tick();
        refill = 1'b0;
        exp_coin.push_back(2'd0); exp_left.push_back(16'd0);
        do_start(16'd500, 16'd0);
        serve(0, 1'b0, coins, dones);
        checks++;
        if (coins != 1 || dones != 1 || error !== 1'b0) begin
            fails++;
            $display("FAIL after_refill: coins %0d done %0d err %b, expected 1 1 0", coins, dones, error);
        end
    endtask

    task automatic test_delayed_ack();
        int coins, dones;
        apply_reset();
        exp_coin.push_back(2'd2); exp_left.push_back(16'd500);
        exp_coin.push_back(2'd0); exp_left.push_back(16'd0);
        do_start(16'd2500, 16'd0);
        serve(3, 1'b1, coins, dones);
        checks++;
        if (coins != 2 || dones != 1 || error !== 1'b0 || change_left !== 16'd0) begin
            fails++;
            $display("FAIL delayed_ack: coins %0d done %0d err %b left %0d, expected 2 1 0 0",
                     coins, dones, error, change_left);
        end
    endtask

    task automatic test_reset_mid();
        int coins, dones;
        int wait_cnt;
        apply_reset();
        do_start(16'd5000, 16'd0);
        wait_cnt = 0;
        while (!coin_req && wait_cnt < 10) begin
            tick();
            wait_cnt++;
        end
        checks++;
        if (coin_req !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_req: coin_req %b, expected 1", coin_req);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (coin_req !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: req %b busy %b err %b, expected 0 0 0", coin_req, busy, error);
        end
        tick();
        reset = 1'b0;
        tick();
        exp_coin.push_back(2'd0); exp_left.push_back(16'd0);
        do_start(16'd500, 16'd0);
        serve(1, 1'b0, coins, dones);
        checks++;
        if (coins != 1 || dones != 1 || error !== 1'b0) begin
            fails++;
            $display("FAIL post_reset_txn: coins %0d done %0d err %b, expected 1 1 0", coins, dones, error);
        end
    endtask

    initial begin
        test_reset();
        test_change();
        test_underpay();
        test_remainder();
        test_hopper();
        test_delayed_ack();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
